sume: RTL and testbench



---
 rtl/sume_pkg.sv | 18 +
 rtl/sume_acc.sv | 23 ++
 rtl/sume.sv | 69 ++++++
 tb/tb_sume.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sume_pkg.sv
// sume_pkg: shared widths, frame FSM state encoding and digit conditioning
// for the sequential decimal adder.
package sume_pkg;

  localparam int DIGIT_W   = 4;   // one BCD digit per cycle
  localparam int WORD_W    = 12;  // binary operand / sum width
  localparam int NDIG      = 3;   // digits per operand
  localparam int MAX_DIGIT = 9;

  // S0..S2 accumulate w1, S3..S5 accumulate w2, S6 registers the sum.
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6} state_t;

  // Non-decimal codes (10..15) are clamped to 9 rather than rejected.
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] x);
    return (x > DIGIT_W'(MAX_DIGIT)) ? DIGIT_W'(MAX_DIGIT) : x;
  endfunction

endpackage

// File: rtl/sume_acc.sv
// sume_acc: combinational decimal accumulator step.
//   acc   in  WORD_W   running binary value
//   digit in  DIGIT_W  incoming decimal digit (saturated to 9)
//   first in  1        start a new operand (ignore acc)
//   nxt   out WORD_W   first ? d : acc*10 + d
module sume_acc
  import sume_pkg::*;
(
  input  logic [WORD_W-1:0]  acc,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               first,
  output logic [WORD_W-1:0]  nxt
);

  logic [WORD_W-1:0] d_ext;
  logic [WORD_W-1:0] x10;

  assign d_ext = WORD_W'(sat_digit(digit));
  // acc*10 as shift-add; operands never exceed 999 so 12 bits suffice.
  assign x10   = (acc << 3) + (acc << 1);
  assign nxt   = first ? d_ext : x10 + d_ext;

endmodule

// File: rtl/sume.sv
// sume: 7-cycle frame decimal adder. Captures two 3-digit decimal operands
// MSD first, one digit per clock, converting to binary on the fly, then
// registers their binary sum on the 7th edge.
//   clk     in  1   rising-edge clock
//   n_reset in  1   async active-low reset, clears FSM and outputs
//   sample  in  4   current decimal digit
//   w1      out 12  first operand (binary)
//   w2      out 12  second operand (binary)
//   sum     out 12  w1 + w2 (binary)
module sume
  import sume_pkg::*;
(
  input  logic               clk,
  input  logic               n_reset,
  input  logic [DIGIT_W-1:0] sample,
  output logic [WORD_W-1:0]  w1,
  output logic [WORD_W-1:0]  w2,
  output logic [WORD_W-1:0]  sum
);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] w1_nxt, w2_nxt;

  sume_acc u_acc_w1 (
    .acc   (w1),
    .digit (sample),
    .first (state == S0),
    .nxt   (w1_nxt)
  );

  sume_acc u_acc_w2 (
    .acc   (w2),
    .digit (sample),
    .first (state == S3),
    .nxt   (w2_nxt)
  );

  // Free-running frame counter; no handshake, source must stay aligned.
  always_comb begin
    state_nxt = S0;
    case (state)
      S0:      state_nxt = S1;
      S1:      state_nxt = S2;
      S2:      state_nxt = S3;
      S3:      state_nxt = S4;
      S4:      state_nxt = S5;
      S5:      state_nxt = S6;
      default: state_nxt = S0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= S0;
      w1    <= '0;
      w2    <= '0;
      sum   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S0, S1, S2: w1  <= w1_nxt;
        S3, S4, S5: w2  <= w2_nxt;
        S6:         sum <= w1 + w2;  // max 1998, MSB stays 0
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_sume.sv
// tb_sume: directed bench for sume with a per-edge scoreboard of expected
// w1/w2/sum plus explicit checks of the documented results.
module tb_sume;

  logic        clk;
  logic        n_reset;
  logic [3:0]  sample;
  logic [11:0] w1, w2, sum;

  sume dut (
    .clk     (clk),
    .n_reset (n_reset),
    .sample  (sample),
    .w1      (w1),
    .w2      (w2),
    .sum     (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] w1;
    logic [11:0] w2;
    logic [11:0] sum;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_st, m_w1, m_w2, m_sum;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one digit, advance the model, push its expectation, clock, compare.
  task automatic step(input logic [3:0] dig);
    int   dd;
    exp_t e;
    dd = (dig > 9) ? 9 : int'(dig);
    case (m_st)
      0:       m_w1 = dd;
      1, 2:    m_w1 = m_w1 * 10 + dd;
      3:       m_w2 = dd;
      4, 5:    m_w2 = m_w2 * 10 + dd;
      default: m_sum = m_w1 + m_w2;
    endcase
    m_st = (m_st + 1) % 7;
    q.push_back('{w1: 12'(m_w1), w2: 12'(m_w2), sum: 12'(m_sum)});
    sample = dig;
    @(posedge clk);
    #1;
    total++;
    assert (q.size() != 0) else begin
      bad++;
      $error("FAIL sb_empty observed=0 expected=1");
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("sb_w1", w1, e.w1);
      chk("sb_w2", w2, e.w2);
      chk("sb_sum", sum, e.sum);
    end
  endtask

  task automatic frame(input logic [3:0] a, b, c, d, e, f, g);
    step(a); step(b); step(c); step(d); step(e); step(f); step(g);
  endtask

  task automatic model_reset();
    m_st = 0; m_w1 = 0; m_w2 = 0; m_sum = 0;
    q.delete();
  endtask

  initial begin
    model_reset();
    n_reset = 1'b0;
    sample  = '0;
    @(posedge clk);
    #1;
    chk("rst_w1", w1, 12'd0);
    chk("rst_w2", w2, 12'd0);
    chk("rst_sum", sum, 12'd0);
    #2 n_reset = 1'b1;

    // Nominal with intermediate operand values
    step(4'd1); chk("nom_w1_a", w1, 12'd1);
    step(4'd2); chk("nom_w1_b", w1, 12'd12);
    step(4'd3); chk("nom_w1", w1, 12'h07B);
    step(4'd4); chk("nom_w2_a", w2, 12'd4);
    step(4'd5); chk("nom_w2_b", w2, 12'd45);
    step(4'd6); chk("nom_w2", w2, 12'h1C8);
    chk("nom_sum_hold", sum, 12'd0);
    step(4'd0); chk("nom_sum", sum, 12'h243);

    // Back-to-back frame: sum holds until S6, w2 holds until S3
    step(4'd0); step(4'd0); step(4'd1);
    chk("b2b_w1", w1, 12'd1);
    chk("b2b_w2_hold", w2, 12'd456);
    step(4'd0); step(4'd0); step(4'd2);
    chk("b2b_sum_hold", sum, 12'd579);
    step(4'd0);
    chk("b2b_sum", sum, 12'd3);

    // Maximum operands
    frame(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd5);
    chk("max_sum", sum, 12'h7CE);
    chk("max_msb", {11'd0, sum[11]}, 12'd0);

    // All zeros
    frame(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("zero_sum", sum, 12'd0);

    // Saturation of non-decimal codes
    frame(4'd15, 4'd0, 4'd10, 4'd0, 4'd0, 4'd12, 4'd7);
    chk("sat_w1", w1, 12'd909);
    chk("sat_w2", w2, 12'd9);
    chk("sat_sum", sum, 12'd918);

    // Mid-frame async reset while in S4
    frame(4'd3, 4'd2, 4'd1, 4'd7, 4'd7, 4'd7, 4'd0);
    step(4'd8); step(4'd8); step(4'd8); step(4'd8);
    n_reset = 1'b0;
    #1;
    chk("mid_rst_w1", w1, 12'd0);
    chk("mid_rst_w2", w2, 12'd0);
    chk("mid_rst_sum", sum, 12'd0);
    model_reset();
    #1 n_reset = 1'b1;
    frame(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0);
    chk("post_rst_sum", sum, 12'd579);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
